// File: rtl/counter_bus_pkg.sv
// counter_bus_pkg: op codes, FSM states and default width shared by counter_bus_master
// and its shadow checker.
package counter_bus_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic OP_LOAD = 1'b0;
    localparam logic OP_READ = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_OE_SETUP,
        ST_SAMPLE,
        ST_TURN
    } state_t;

endpackage

// File: rtl/counter_shadow.sv
// counter_shadow: free-running mirror of the external counter plus a compare of each
// sampled bus value against it; the error pulse lines up with the response pulse.
module counter_shadow
    import counter_bus_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ctr_load,
    input  logic [WIDTH-1:0] ctr_data,
    input  logic             sample,
    input  logic [WIDTH-1:0] bus_value,
    output logic             chk_err
);

    logic [WIDTH-1:0] shadow;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow  <= '0;
            chk_err <= 1'b0;
        end else begin
            shadow  <= ctr_load ? ctr_data : shadow + 1'b1;
            chk_err <= sample && (bus_value != shadow);
        end
    end

endmodule

// File: rtl/counter_bus_master.sv
// counter_bus_master: host LOAD/READ commands to the programmable counter's pins.
// Define CTR_SHADOW_CHECK_EN to add the shadow-counter consistency check on chk_err.
module counter_bus_master
    import counter_bus_pkg::*;
#(
    parameter int WIDTH         = DEFAULT_WIDTH,
    parameter int SETTLE_CYCLES = 1,
    parameter int TURN_CYCLES   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_data,
    output logic             chk_err,
    output logic             ctr_load,
    output logic [WIDTH-1:0] ctr_data,
    output logic             ctr_oe_n,
    input  logic [WIDTH-1:0] ctr_bus
);

    localparam int TMAX = SETTLE_CYCLES > TURN_CYCLES ? SETTLE_CYCLES : TURN_CYCLES;
    localparam int TW   = $clog2(TMAX) + 1;

    state_t          state, next_state;
    logic [TW-1:0]   timer;
    logic            accept;

    assign accept = cmd_valid && cmd_ready;

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:     if (accept) next_state = (cmd_op == OP_READ) ? ST_OE_SETUP : ST_LOAD;
            ST_LOAD:     next_state = ST_IDLE;
            ST_OE_SETUP: if (timer == TW'(SETTLE_CYCLES - 1)) next_state = ST_SAMPLE;
            ST_SAMPLE:   next_state = ST_TURN;
            ST_TURN:     if (timer == TW'(TURN_CYCLES - 1)) next_state = ST_IDLE;
            default:     next_state = ST_IDLE;
        endcase
    end

    // Pin outputs are registered from next_state so they line up with the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            timer     <= '0;
            cmd_ready <= 1'b0;
            ctr_load  <= 1'b0;
            ctr_data  <= '0;
            ctr_oe_n  <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state     <= next_state;
            timer     <= (next_state != state) ? '0 : timer + 1'b1;
            cmd_ready <= next_state == ST_IDLE;
            ctr_load  <= next_state == ST_LOAD;
            ctr_oe_n  <= !(next_state == ST_OE_SETUP || next_state == ST_SAMPLE);
            rsp_valid <= state == ST_SAMPLE;
            if (accept && cmd_op == OP_LOAD) ctr_data <= cmd_data;
            if (state == ST_SAMPLE) rsp_data <= ctr_bus;
        end
    end

`ifdef CTR_SHADOW_CHECK_EN
    counter_shadow #(.WIDTH(WIDTH)) u_shadow (
        .clk       (clk),
        .reset     (reset),
        .ctr_load  (ctr_load),
        .ctr_data  (ctr_data),
        .sample    (state == ST_SAMPLE),
        .bus_value (ctr_bus),
        .chk_err   (chk_err)
    );
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_counter_bus_master.sv
// tb_counter_bus_master: two DUTs (settle/turn 1/1 and 3/2), each with a free-running
// counter device on its bus; directed and random LOAD/READ traffic checked against cycle rules.
module tb_counter_bus_master;

    localparam int W = 8;
`ifdef CTR_SHADOW_CHECK_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic         cmd_valid [2];
    logic         cmd_op    [2];
    logic [W-1:0] cmd_data  [2];
    logic         cmd_ready [2];
    logic         rsp_valid [2];
    logic [W-1:0] rsp_data  [2];
    logic         chk_err   [2];
    logic         ctr_load  [2];
    logic [W-1:0] ctr_data  [2];
    logic         ctr_oe_n  [2];
    logic [W-1:0] cnt       [2];
    logic         frc       [2];
    logic [W-1:0] last_load [2];
    logic [W-1:0] last_rsp  [2];
    wire  [W-1:0] bus0, bus1;
    int           cyc = 0;
    int           total = 0, bad = 0;

    assign bus0 = ctr_oe_n[0] ? 'z : (frc[0] ? 8'h55 : cnt[0]);
    assign bus1 = ctr_oe_n[1] ? 'z : (frc[1] ? 8'h55 : cnt[1]);

    // Counter devices: free-running, loaded from the pins after a ctr_load cycle.
    always @(posedge clk or posedge reset)
        for (int i = 0; i < 2; i++)
            cnt[i] <= reset ? '0 : (ctr_load[i] ? ctr_data[i] : cnt[i] + 1'b1);

    always @(posedge clk) cyc <= cyc + 1;

    counter_bus_master #(.WIDTH(W), .SETTLE_CYCLES(1), .TURN_CYCLES(1)) u0 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_op(cmd_op[0]), .cmd_data(cmd_data[0]), .rsp_valid(rsp_valid[0]),
        .rsp_data(rsp_data[0]), .chk_err(chk_err[0]), .ctr_load(ctr_load[0]),
        .ctr_data(ctr_data[0]), .ctr_oe_n(ctr_oe_n[0]), .ctr_bus(bus0)
    );

    counter_bus_master #(.WIDTH(W), .SETTLE_CYCLES(3), .TURN_CYCLES(2)) u1 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_op(cmd_op[1]), .cmd_data(cmd_data[1]), .rsp_valid(rsp_valid[1]),
        .rsp_data(rsp_data[1]), .chk_err(chk_err[1]), .ctr_load(ctr_load[1]),
        .ctr_data(ctr_data[1]), .ctr_oe_n(ctr_oe_n[1]), .ctr_bus(bus1)
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < 2; i++) chk("load_oe_exclusive", {31'd0, ctr_load[i] & ~ctr_oe_n[i]}, 32'd0);
    endtask

    task automatic wait_ready(int d);
        int n = 0;
        while (cmd_ready[d] !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("ready_timeout", {31'd0, cmd_ready[d]}, 32'd1);
    endtask

    task automatic do_load(int d, logic [W-1:0] v);
        wait_ready(d);
        cmd_valid[d] = 1'b1; cmd_op[d] = 1'b0; cmd_data[d] = v;
        tick();
        chk("load_pulse", {31'd0, ctr_load[d]}, 32'd1);
        chk("load_data", {24'd0, ctr_data[d]}, {24'd0, v});
        chk("load_busy", {31'd0, cmd_ready[d]}, 32'd0);
        cmd_valid[d] = 1'($urandom); cmd_op[d] = 1'($urandom); cmd_data[d] = 8'($urandom);
        tick();
        chk("load_end", {31'd0, ctr_load[d]}, 32'd0);
        chk("load_hold", {24'd0, ctr_data[d]}, {24'd0, v});
        chk("load_ready", {31'd0, cmd_ready[d]}, 32'd1);
        cmd_valid[d] = 1'b0;
        last_load[d] = v;
    endtask

    // Accept, S oe-setup cycles, one sample cycle, then T turn cycles with the response in the first.
    task automatic do_read(int d, output logic [W-1:0] got, output int scyc);
        int s = d ? 3 : 1;
        int t = d ? 2 : 1;
        logic [W-1:0] eb, ec;
        eb = '0; ec = '0; scyc = 0;
        wait_ready(d);
        cmd_valid[d] = 1'b1; cmd_op[d] = 1'b1; cmd_data[d] = 8'($urandom);
        for (int k = 1; k <= s + 2 + t; k++) begin
            tick();
            chk("rd_oe_n", {31'd0, ctr_oe_n[d]}, (k <= s + 1) ? 32'd0 : 32'd1);
            chk("rd_rsp_valid", {31'd0, rsp_valid[d]}, (k == s + 2) ? 32'd1 : 32'd0);
            chk("rd_ready", {31'd0, cmd_ready[d]}, (k == s + 2 + t) ? 32'd1 : 32'd0);
            chk("rd_no_load", {31'd0, ctr_load[d]}, 32'd0);
            chk("rd_data_hold", {24'd0, ctr_data[d]}, {24'd0, last_load[d]});
            if (k == s + 1) begin
                eb = frc[d] ? 8'h55 : cnt[d];
                ec = cnt[d];
                scyc = cyc;
            end
            if (k < s + 2) chk("rsp_hold", {24'd0, rsp_data[d]}, {24'd0, last_rsp[d]});
            else begin
                chk("rsp_data", {24'd0, rsp_data[d]}, {24'd0, eb});
                if (k == s + 2) chk("chk_err", {31'd0, chk_err[d]}, {31'd0, SHADOW && (eb != ec)});
                else chk("chk_err_idle", {31'd0, chk_err[d]}, 32'd0);
            end
            cmd_valid[d] = (k == s + 2 + t) ? 1'b0 : 1'($urandom);
            cmd_op[d] = 1'($urandom); cmd_data[d] = 8'($urandom);
        end
        last_rsp[d] = eb;
        got = eb;
    endtask

    logic [W-1:0] g, pg;
    int sc, ps;

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            cmd_valid[i] = 1'b0; cmd_op[i] = 1'b0; cmd_data[i] = '0;
            frc[i] = 1'b0; last_load[i] = '0; last_rsp[i] = '0;
        end
        reset = 1'b1;
        cmd_valid[0] = 1'b1; cmd_op[0] = 1'b0; cmd_data[0] = 8'h10;
        tick();
        tick();
        for (int i = 0; i < 2; i++) begin
            chk("rst_oe_n", {31'd0, ctr_oe_n[i]}, 32'd1);
            chk("rst_load", {31'd0, ctr_load[i]}, 32'd0);
            chk("rst_ready", {31'd0, cmd_ready[i]}, 32'd0);
            chk("rst_rsp_valid", {31'd0, rsp_valid[i]}, 32'd0);
            chk("rst_rsp_data", {24'd0, rsp_data[i]}, 32'd0);
            chk("rst_ctr_data", {24'd0, ctr_data[i]}, 32'd0);
            chk("rst_chk_err", {31'd0, chk_err[i]}, 32'd0);
        end
        reset = 1'b0;
        tick();
        chk("first_ready", {31'd0, cmd_ready[0]}, 32'd1);
        chk("no_accept_yet", {31'd0, ctr_load[0]}, 32'd0);
        tick();
        chk("first_load", {31'd0, ctr_load[0]}, 32'd1);
        chk("first_load_data", {24'd0, ctr_data[0]}, 32'h10);
        cmd_valid[0] = 1'b0;
        last_load[0] = 8'h10;
        tick();
        chk("first_load_once", {31'd0, ctr_load[0]}, 32'd0);
        do_read(0, g, sc);
        chk("ld_rd_value", {24'd0, rsp_data[0]}, 32'h12);

        do_load(0, 8'hFE);
        do_read(0, g, sc);
        chk("wrap_value", {24'd0, rsp_data[0]}, 32'h00);

        do_read(1, g, sc);
        for (int i = 0; i < 4; i++) begin
            pg = g; ps = sc;
            do_read(1, g, sc);
            chk("read_period", sc - ps, 32'd7);
            chk("read_step", {24'd0, 8'(g - pg)}, {24'd0, 8'(sc - ps)});
        end

        wait_ready(1);
        cmd_valid[1] = 1'b1; cmd_op[1] = 1'b1;
        tick();
        cmd_valid[1] = 1'b0;
        chk("mid_oe_low", {31'd0, ctr_oe_n[1]}, 32'd0);
        tick();
        chk("mid_oe_low2", {31'd0, ctr_oe_n[1]}, 32'd0);
        #2 reset = 1'b1;
        #1;
        chk("async_oe_n", {31'd0, ctr_oe_n[1]}, 32'd1);
        chk("async_load", {31'd0, ctr_load[1]}, 32'd0);
        chk("async_rsp", {31'd0, rsp_valid[1]}, 32'd0);
        chk("async_ready", {31'd0, cmd_ready[1]}, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin last_load[i] = '0; last_rsp[i] = '0; end
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("post_rst_no_rsp", {31'd0, rsp_valid[1]}, 32'd0);
            chk("post_rst_oe_n", {31'd0, ctr_oe_n[1]}, 32'd1);
        end
        do_read(1, g, sc);

        do_load(0, 8'h10);
        frc[0] = 1'b1;
        do_read(0, g, sc);
        frc[0] = 1'b0;
        chk("forced_value", {24'd0, rsp_data[0]}, 32'h55);

        for (int n = 0; n < 24; n++) begin
            int d = int'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) do_load(d, 8'($urandom));
            else do_read(d, g, sc);
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
